// File: rtl/ucontrol_pkg.sv
// Shared definitions for the microcode patch loader.
// Command codes, widths and loader state encodings.
package ucontrol_pkg;

    localparam int CS_WIDTH   = 64;
    localparam int TAG_WIDTH  = 9;
    localparam int BEAT_WIDTH = 16;
    localparam int CMD_WIDTH  = 7;
    localparam int CNT_WIDTH  = 5;

    typedef logic [CMD_WIDTH-1:0] cmd_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;

    localparam cmd_t CMD_WRITE = 7'h01;
    localparam cmd_t CMD_INVAL = 7'h02;
    localparam cmd_t CMD_CLEAR = 7'h03;

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_D0     = 3'd1,
        ST_D1     = 3'd2,
        ST_D2     = 3'd3,
        ST_D3     = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    function automatic logic cmd_known(input cmd_t c);
        return (c == CMD_WRITE) || (c == CMD_INVAL) || (c == CMD_CLEAR);
    endfunction

endpackage

// File: rtl/ucontrol_patch_cam.sv
// Patch table storage: tag match, hit word mux,
// lowest-free-entry selection and valid-entry count.
module ucontrol_patch_cam
    import ucontrol_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic                 inv_i,
    input  logic                 clr_i,
    input  tag_t                 wtag_i,
    input  logic [CS_WIDTH-1:0]  wdata_i,
    input  tag_t                 ltag_i,
    input  logic [CS_WIDTH-1:0]  rom_cs_i,
    output logic [CS_WIDTH-1:0]  cs_o,
    output logic                 hit_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 drop_o
);

    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] vld_q;
    tag_t                   tag_q  [NUM_ENTRIES];
    logic [CS_WIDTH-1:0]    word_q [NUM_ENTRIES];

    logic          wmatch;
    logic [IW-1:0] widx;
    logic          free_any;
    logic [IW-1:0] fidx;
    logic [IW-1:0] sel;
    logic          wr_ok;

    // Locate the write tag and the lowest-index free slot
    always_comb begin
        wmatch   = 1'b0;
        widx     = '0;
        free_any = 1'b0;
        fidx     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (vld_q[i] && (tag_q[i] == wtag_i)) begin
                wmatch = 1'b1;
                widx   = IW'(i);
            end
            if (!free_any && !vld_q[i]) begin
                free_any = 1'b1;
                fidx     = IW'(i);
            end
        end
    end

    // An existing tag is overwritten in place; otherwise take a free slot
    always_comb begin
        sel    = wmatch ? widx : fidx;
        wr_ok  = we_i & (wmatch | free_any);
        drop_o = we_i & ~wmatch & ~free_any;
    end

    // Zero-cycle lookup; tags are unique so at most one entry fires
    always_comb begin
        hit_o = 1'b0;
        cs_o  = rom_cs_i;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (vld_q[i] && (tag_q[i] == ltag_i)) begin
                hit_o = 1'b1;
                cs_o  = word_q[i];
            end
        end
    end

    // Number of valid entries
    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            count_o = count_o + CNT_WIDTH'(vld_q[i]);
        end
    end

    // Entry valid bits
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else if (inv_i && wmatch) begin
            vld_q[widx] <= 1'b0;
        end else if (wr_ok) begin
            vld_q[sel] <= 1'b1;
        end
    end

    // Entry tag and word payload; meaningless while invalid
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tag_q[sel]  <= wtag_i;
            word_q[sel] <= wdata_i;
        end
    end

endmodule

// File: rtl/ucontrol_patch_loader.sv
// Microcode patch loader: assembles 16-bit load beats into
// control-word patches and overlays them on the ROM output.
module ucontrol_patch_loader
    import ucontrol_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [BEAT_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic [7:0]            lk_opcode,
    input  logic                  lk_opcode_size,
    input  logic [CS_WIDTH-1:0]   rom_cs,
    output logic [CS_WIDTH-1:0]   control_signal,
    output logic                  patch_hit,
    output logic [CNT_WIDTH-1:0]  patch_count,
    output logic                  load_err
);

    state_e              state_q;
    state_e              state_d;
    cmd_t                cmd_q;
    tag_t                tag_q;
    logic [CS_WIDTH-1:0] buf_q;
    logic                err_q;

    logic beat;
    cmd_t hdr_cmd;
    tag_t hdr_tag;
    logic cam_we;
    logic cam_inv;
    logic cam_clr;
    logic cam_drop;

    assign beat     = load_valid & load_ready;
    assign hdr_cmd  = load_data[15:9];
    assign hdr_tag  = load_data[8:0];
    assign load_err = err_q;

    // Loader state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet sequencing; unknown commands are swallowed in HDR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (beat) begin
                    if (hdr_cmd == CMD_WRITE) begin
                        state_d = ST_D0;
                    end else if (cmd_known(hdr_cmd)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_D0:     if (beat) state_d = ST_D1;
            ST_D1:     if (beat) state_d = ST_D2;
            ST_D2:     if (beat) state_d = ST_D3;
            ST_D3:     if (beat) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_HDR;
            default:   state_d = ST_HDR;
        endcase
    end

    // Handshake and table update strobes
    always_comb begin
        load_ready = (state_q != ST_COMMIT);
        cam_we     = (state_q == ST_COMMIT) && (cmd_q == CMD_WRITE);
        cam_inv    = (state_q == ST_COMMIT) && (cmd_q == CMD_INVAL);
        cam_clr    = (state_q == ST_COMMIT) && (cmd_q == CMD_CLEAR);
    end

    // Header capture, beat assembly (LSB first) and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_q <= '0;
            tag_q <= '0;
            buf_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (beat) begin
                case (state_q)
                    ST_HDR: begin
                        cmd_q <= hdr_cmd;
                        tag_q <= hdr_tag;
                        if (!cmd_known(hdr_cmd)) begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_D0:   buf_q[15:0]  <= load_data;
                    ST_D1:   buf_q[31:16] <= load_data;
                    ST_D2:   buf_q[47:32] <= load_data;
                    ST_D3:   buf_q[63:48] <= load_data;
                    default: ;
                endcase
            end
            if (cam_drop) begin
                err_q <= 1'b1;
            end
        end
    end

    ucontrol_patch_cam #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_cam (
        .clk      (clk),
        .rst_ni   (reset),
        .we_i     (cam_we),
        .inv_i    (cam_inv),
        .clr_i    (cam_clr),
        .wtag_i   (tag_q),
        .wdata_i  (buf_q),
        .ltag_i   ({lk_opcode_size, lk_opcode}),
        .rom_cs_i (rom_cs),
        .cs_o     (control_signal),
        .hit_o    (patch_hit),
        .count_o  (patch_count),
        .drop_o   (cam_drop)
    );

endmodule

// File: tb/tb_ucontrol_patch_loader.sv
// Directed bench for the microcode patch loader.
// Lookup expectations flow through a scoreboard queue.
module tb_ucontrol_patch_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [7:0]  lk_opcode;
    logic        lk_opcode_size;
    logic [63:0] rom_cs;
    logic [63:0] control_signal;
    logic        patch_hit;
    logic [4:0]  patch_count;
    logic        load_err;

    int n_assert = 0;
    int n_fail   = 0;
    int rdy_low  = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic [63:0] cs;
    } exp_t;

    exp_t sb[$];

    localparam logic [63:0] ROM = 64'h5A5A_0000_C3C3_FFFF;
    localparam logic [63:0] W1  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W2  = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W3  = 64'hCAFE_F00D_1357_2468;
    localparam logic [63:0] W4  = 64'h8001_4002_2004_1008;
    localparam logic [63:0] W9  = 64'h9999_8888_7777_6666;

    ucontrol_patch_loader #(
        .NUM_ENTRIES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .lk_opcode      (lk_opcode),
        .lk_opcode_size (lk_opcode_size),
        .rom_cs         (rom_cs),
        .control_signal (control_signal),
        .patch_hit      (patch_hit),
        .patch_count    (patch_count),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && !load_ready) rdy_low <= rdy_low + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chkb(input string name, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", name, obs, exp);
        end
    endtask

    task automatic chkc(input string name, input logic [4:0] obs, input logic [4:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", name, obs, exp);
        end
    endtask

    task automatic chki(input string name, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
        end
    endtask

    task automatic lk(input string name, input logic [8:0] tag,
                      input logic exp_hit, input logic [63:0] exp_cs);
        exp_t e;
        exp_t g;
        {lk_opcode_size, lk_opcode} = tag;
        e.name = name;
        e.hit  = exp_hit;
        e.cs   = exp_cs;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        chkb({g.name, "_hit"}, patch_hit, g.hit);
        chkw({g.name, "_cs"}, control_signal, g.cs);
    endtask

    task automatic send_beat(input logic [15:0] d);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chkb("beat_ready", load_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic write_pkt(input logic [8:0] tag, input logic [63:0] w, input bit gap);
        send_beat({7'h01, tag});
        for (int k = 0; k < 4; k++) begin
            if (gap) begin
                load_valid = 1'b0;
                @(negedge clk);
            end
            send_beat(w[16*k +: 16]);
        end
        load_valid = 1'b0;
    endtask

    task automatic cmd_pkt(input logic [6:0] cmd, input logic [8:0] tag);
        send_beat({cmd, tag});
        load_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int low0;
        logic [63:0] w;
        reset          = 1'b0;
        load_valid     = 1'b0;
        load_data      = '0;
        lk_opcode      = '0;
        lk_opcode_size = 1'b0;
        rom_cs         = ROM;
        repeat (3) @(negedge clk);
        chkb("rst_ready", load_ready, 1'b1);
        chkc("rst_count", patch_count, 5'd0);
        chkb("rst_err", load_err, 1'b0);
        lk("rst_lk", 9'h03A, 1'b0, ROM);
        reset = 1'b1;
        @(negedge clk);

        write_pkt(9'h03A, W1, 1'b0);
        @(negedge clk);
        lk("t1_size0", 9'h03A, 1'b1, W1);
        lk("t1_size1", 9'h13A, 1'b0, ROM);
        chkc("t1_count", patch_count, 5'd1);

        for (int i = 0; i < 7; i++) begin
            w = 64'h1111_2222_3333_0000 + 64'(i);
            write_pkt(9'h040 + 9'(i), w, 1'b0);
            @(negedge clk);
        end
        chkc("t2_full_count", patch_count, 5'd8);
        chkb("t2_err_before", load_err, 1'b0);
        lk("t2_fill", 9'h043, 1'b1, 64'h1111_2222_3333_0003);
        write_pkt(9'h1FF, W9, 1'b0);
        @(negedge clk);
        chkb("t2_err_full", load_err, 1'b1);
        chkc("t2_count_full", patch_count, 5'd8);
        lk("t2_dropped", 9'h1FF, 1'b0, ROM);

        write_pkt(9'h03A, W2, 1'b0);
        chkb("t4_ready_commit", load_ready, 1'b0);
        lk("t4_old", 9'h03A, 1'b1, W1);
        @(negedge clk);
        lk("t4_new", 9'h03A, 1'b1, W2);
        chkc("t4_count", patch_count, 5'd8);
        chkb("t4_ready_after", load_ready, 1'b1);

        do_reset();
        chkb("rst2_err", load_err, 1'b0);
        chkc("rst2_count", patch_count, 5'd0);
        lk("rst2_lk", 9'h03A, 1'b0, ROM);

        low0 = rdy_low;
        write_pkt(9'h155, W3, 1'b1);
        repeat (3) @(negedge clk);
        chki("t3_ready_low", rdy_low - low0, 1);
        lk("t3_toggled", 9'h155, 1'b1, W3);
        write_pkt(9'h156, W3, 1'b0);
        @(negedge clk);
        lk("t3_b2b", 9'h156, 1'b1, W3);
        chkc("t3_count", patch_count, 5'd2);

        cmd_pkt(7'h02, 9'h155);
        @(negedge clk);
        lk("t5_inval", 9'h155, 1'b0, ROM);
        chkc("t5_inval_count", patch_count, 5'd1);
        cmd_pkt(7'h02, 9'h0FE);
        @(negedge clk);
        chkb("t5_inval_miss_err", load_err, 1'b0);
        chkc("t5_inval_miss_count", patch_count, 5'd1);
        cmd_pkt(7'h03, 9'h000);
        @(negedge clk);
        chkc("t5_clear_count", patch_count, 5'd0);
        lk("t5_clear", 9'h156, 1'b0, ROM);
        cmd_pkt(7'h7F, 9'h0AA);
        chkb("t5_bad_ready", load_ready, 1'b1);
        chkb("t5_bad_err", load_err, 1'b1);
        write_pkt(9'h0AA, W4, 1'b0);
        @(negedge clk);
        lk("t5_after_bad", 9'h0AA, 1'b1, W4);
        chkc("t5_after_count", patch_count, 5'd1);

        do_reset();
        send_beat({7'h01, 9'h0BB});
        send_beat(W1[15:0]);
        send_beat(W1[31:16]);
        reset      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chkb("t6_ready", load_ready, 1'b1);
        chkc("t6_count", patch_count, 5'd0);
        repeat (3) @(negedge clk);
        lk("t6_lk", 9'h0BB, 1'b0, ROM);
        chkc("t6_count_late", patch_count, 5'd0);
        write_pkt(9'h0BB, W2, 1'b0);
        @(negedge clk);
        lk("t6_rewrite", 9'h0BB, 1'b1, W2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
